// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory steps,
// bounds memory waits with a timeout, and latches illegal-op/timeout traps.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   wait_cnt;
  logic            mem_wait;
  logic            timeout;
  logic [1:0]      cause_next;
  logic            trap_q;
  logic [1:0]      trap_cause_q;

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'b000:  return sub_ok ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  assign mem_wait = ((state == FETCH) || (state == MEMREAD) || (state == MEMWRITE)) && !mem_ready;
  // The counter holds the number of wait cycles already spent; one more wait
  // beyond MEM_TIMEOUT is a fault, while mem_ready on that cycle still wins.
  assign timeout  = mem_wait && (wait_cnt == CW'(MEM_TIMEOUT));

  always_comb begin
    // NOTE: every output and the next state get a default before the case so
    // that no path leaves them unassigned; otherwise synthesis infers latches.
    state_next = state;
    cause_next = 2'b00;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    instr_done = 1'b0;
    case (Op)
      OP_SW:     ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase

    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready)    state_next = DECODE;
        else if (timeout) state_next = TRAP;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECR;
          OP_ITYPE:     state_next = EXECI;
          OP_BRANCH:    state_next = BRANCH;
          OP_JAL:       state_next = JAL;
          default: begin
            state_next = TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (Op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready)    state_next = MEMWB;
        else if (timeout) state_next = TRAP;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
        if (mem_ready)    state_next = FETCH;
        else if (timeout) state_next = TRAP;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(funct3, funct7[5]);
        state_next = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(funct3, 1'b0);
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = Zero ^ funct3[0];
        instr_done = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = TRAP;
    endcase

    if (timeout && !mem_ready) cause_next = CAUSE_TIMEOUT;

    // Reset overrides every transition and silences the datapath this cycle.
    if (rst) begin
      state_next = FETCH;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state        <= FETCH;
      wait_cnt     <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= 2'b00;
    end else begin
      state <= state_next;
      if (state_next != state) wait_cnt <= '0;
      else if (mem_wait)       wait_cnt <= wait_cnt + CW'(1);
      if ((state_next == TRAP) && (state != TRAP)) begin
        trap_q       <= 1'b1;
        trap_cause_q <= cause_next;
      end
    end
  end

  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each driven cycle queues its expected
// output word, and a negedge monitor pops and compares it.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] Op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'b0000000;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, trap_cause;
  logic [2:0] ALUControl;
  logic       instr_done, trap;

  mc_control_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instr_done(instr_done),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  typedef struct {
    string       tag;
    logic [19:0] exp;
  } sb_t;

  sb_t         q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [1:0]  imm;
  logic [6:0]  p_op;
  logic [2:0]  p_f3;
  logic [6:0]  p_f7;
  logic        p_z;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      sb_t e;
      e = q.pop_front();
      check(e.tag, {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                    ALUSrcB, ALUControl, ImmSrc, instr_done, trap, trap_cause}, e.exp);
    end
  end

  function automatic logic [19:0] mk(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, sa, sb, input logic [2:0] alu,
                                     input logic done, tr, input logic [1:0] cause);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, done, tr, cause};
  endfunction

  function automatic logic [19:0] e_fetch(input logic mr);
    return mk(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0, 2'b00);
  endfunction
  function automatic logic [19:0] e_decode();
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0, 2'b00);
  endfunction
  function automatic logic [19:0] e_exec(input logic is_i, input logic [2:0] alu);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, is_i ? 2'b01 : 2'b00, alu, 0, 0, 2'b00);
  endfunction
  function automatic logic [19:0] e_aluwb();
    return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0, 2'b00);
  endfunction
  function automatic logic [19:0] e_memadr();
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0, 2'b00);
  endfunction
  function automatic logic [19:0] e_memread();
    return mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 2'b00);
  endfunction
  function automatic logic [19:0] e_memwb();
    return mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0, 2'b00);
  endfunction
  function automatic logic [19:0] e_memwrite(input logic mr);
    return mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, mr, 0, 2'b00);
  endfunction
  function automatic logic [19:0] e_branch(input logic pcw);
    return mk(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 1, 0, 2'b00);
  endfunction
  function automatic logic [19:0] e_jal();
    return mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0, 2'b00);
  endfunction
  function automatic logic [19:0] e_trap(input logic [1:0] cause);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1, cause);
  endfunction
  function automatic logic [19:0] e_rst(input logic tr, input logic [1:0] cause);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, tr, cause);
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z);
    p_op = op; p_f3 = f3; p_f7 = f7; p_z = z;
    case (op)
      SW:      imm = 2'b01;
      BR:      imm = 2'b10;
      JL:      imm = 2'b11;
      default: imm = 2'b00;
    endcase
  endtask

  task automatic step(input logic r, input logic mr, input logic [19:0] e, input string tag);
    @(posedge clk);
    #1;
    Op = p_op; funct3 = p_f3; funct7 = p_f7; Zero = p_z;
    rst = r; mem_ready = mr;
    q.push_back('{tag, e});
  endtask

  task automatic run_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [2:0] alu, input string name);
    set_instr(op, f3, f7, 1'b0);
    step(0, 1, e_fetch(1), {name, ".fetch"});
    step(0, 1, e_decode(), {name, ".decode"});
    step(0, 1, e_exec(op == IT, alu), {name, ".exec"});
    step(0, 1, e_aluwb(), {name, ".wb"});
  endtask

  initial begin
    set_instr(RT, 3'b000, 7'b0000000, 1'b0);
    step(1, 1, e_rst(0, 2'b00), "reset");

    run_alu(RT, 3'b000, 7'b0000000, 3'b000, "add");
    run_alu(RT, 3'b000, 7'b0100000, 3'b001, "sub");
    run_alu(IT, 3'b000, 7'b0100000, 3'b000, "addi_f7");
    run_alu(RT, 3'b110, 7'b0000000, 3'b011, "or");
    run_alu(IT, 3'b111, 7'b0000000, 3'b010, "andi");
    run_alu(RT, 3'b010, 7'b0000000, 3'b101, "slt");
    run_alu(IT, 3'b100, 7'b0000000, 3'b000, "xori_dflt");

    // lw with three wait cycles in MEMREAD
    set_instr(LW, 3'b010, 7'b0, 1'b0);
    step(0, 1, e_fetch(1), "lw.fetch");
    step(0, 1, e_decode(), "lw.decode");
    step(0, 1, e_memadr(), "lw.memadr");
    for (int i = 0; i < 3; i++) step(0, 0, e_memread(), "lw.memread_wait");
    step(0, 1, e_memread(), "lw.memread_ready");
    step(0, 1, e_memwb(), "lw.memwb");

    // sw with one wait cycle
    set_instr(SW, 3'b010, 7'b0, 1'b0);
    step(0, 1, e_fetch(1), "sw.fetch");
    step(0, 1, e_decode(), "sw.decode");
    step(0, 1, e_memadr(), "sw.memadr");
    step(0, 0, e_memwrite(0), "sw.memwrite_wait");
    step(0, 1, e_memwrite(1), "sw.memwrite_done");

    // branches: beq/bne with Zero=1, beq with Zero=0
    set_instr(BR, 3'b000, 7'b0, 1'b1);
    step(0, 1, e_fetch(1), "beq.fetch");
    step(0, 1, e_decode(), "beq.decode");
    step(0, 1, e_branch(1), "beq_z1.branch");
    set_instr(BR, 3'b001, 7'b0, 1'b1);
    step(0, 1, e_fetch(1), "bne.fetch");
    step(0, 1, e_decode(), "bne.decode");
    step(0, 1, e_branch(0), "bne_z1.branch");
    set_instr(BR, 3'b000, 7'b0, 1'b0);
    step(0, 1, e_fetch(1), "beq0.fetch");
    step(0, 1, e_decode(), "beq0.decode");
    step(0, 1, e_branch(0), "beq_z0.branch");

    set_instr(JL, 3'b000, 7'b0, 1'b0);
    step(0, 1, e_fetch(1), "jal.fetch");
    step(0, 1, e_decode(), "jal.decode");
    step(0, 1, e_jal(), "jal.jal");
    step(0, 1, e_aluwb(), "jal.wb");

    // 15 waits are tolerated when mem_ready arrives on the limit cycle
    set_instr(RT, 3'b000, 7'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(0, 0, e_fetch(0), "edge.fetch_wait");
    step(0, 1, e_fetch(1), "edge.fetch_ready");
    step(0, 1, e_decode(), "edge.decode");
    step(0, 1, e_exec(0, 3'b000), "edge.exec");
    step(0, 1, e_aluwb(), "edge.wb");

    // one more wait in FETCH traps with cause 10, then reset recovers
    for (int i = 0; i < 16; i++) step(0, 0, e_fetch(0), "to.fetch_wait");
    step(0, 0, e_trap(2'b10), "to.trap");
    step(0, 1, e_trap(2'b10), "to.trap_absorb");
    step(1, 1, e_rst(1, 2'b10), "to.reset");
    step(0, 1, e_fetch(1), "to.refetch");
    step(0, 1, e_decode(), "to.decode");
    step(0, 1, e_exec(0, 3'b000), "to.exec");
    step(0, 1, e_aluwb(), "to.wb");

    // timeout in MEMREAD
    set_instr(LW, 3'b010, 7'b0, 1'b0);
    step(0, 1, e_fetch(1), "lwto.fetch");
    step(0, 1, e_decode(), "lwto.decode");
    step(0, 1, e_memadr(), "lwto.memadr");
    for (int i = 0; i < 16; i++) step(0, 0, e_memread(), "lwto.memread_wait");
    step(0, 1, e_trap(2'b10), "lwto.trap");
    step(1, 1, e_rst(1, 2'b10), "lwto.reset");

    // illegal opcode
    set_instr(7'b0000000, 3'b000, 7'b0, 1'b0);
    step(0, 1, e_fetch(1), "ill.fetch");
    step(0, 1, e_decode(), "ill.decode");
    step(0, 1, e_trap(2'b01), "ill.trap");
    step(0, 0, e_trap(2'b01), "ill.trap_absorb");
    step(1, 1, e_rst(1, 2'b01), "ill.reset");

    // reset in the middle of a store
    set_instr(SW, 3'b010, 7'b0, 1'b0);
    step(0, 1, e_fetch(1), "swr.fetch");
    step(0, 1, e_decode(), "swr.decode");
    step(0, 1, e_memadr(), "swr.memadr");
    step(0, 0, e_memwrite(0), "swr.memwrite");
    step(1, 0, e_rst(0, 2'b00), "swr.reset_in_memwrite");
    step(0, 1, e_fetch(1), "swr.refetch");
    step(0, 1, e_decode(), "swr.decode2");
    step(0, 1, e_memadr(), "swr.memadr2");
    step(0, 1, e_memwrite(1), "swr.memwrite_done");

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drain", 20'(q.size()), 20'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
